// File: rtl/result_streamer.sv
// Streams a finished key-search result: key bytes MSB first, then the winning core's message, or a single status byte on failure.
// Optional RESULT_CHECKSUM_EN appends an XOR checksum byte after the message.
module result_streamer #(
    parameter int                 NUM_CORES          = 2,
    parameter int                 LOG_NUM_CORES      = 8,
    parameter int                 MESSAGE_LENGTH     = 32,
    parameter int                 MESSAGE_LOG_LENGTH = 5,
    parameter int                 KEY_LENGTH         = 3,
    parameter int                 RAM_WIDTH          = 8,
    parameter logic [RAM_WIDTH-1:0] FAIL_CODE        = 8'hEE
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              finish,
    input  logic                              success,
    input  logic [LOG_NUM_CORES-1:0]          core_ptr,
    input  logic [KEY_LENGTH*RAM_WIDTH-1:0]   key,
    output logic [MESSAGE_LOG_LENGTH-1:0]     a_raddr,
    input  logic [NUM_CORES*RAM_WIDTH-1:0]    a_rdata,
    output logic [RAM_WIDTH-1:0]              out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
    output logic                              busy
);

    localparam int KEY_W       = KEY_LENGTH * RAM_WIDTH;
    localparam int KEY_CNT_W   = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
    localparam logic [KEY_CNT_W-1:0]          KEY_LAST = KEY_CNT_W'(KEY_LENGTH - 1);
    localparam logic [MESSAGE_LOG_LENGTH-1:0] MSG_LAST = MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1);

    typedef enum logic [2:0] {
        IDLE, KEY, RD_REQ, RD_WAIT, MSG, FAILB, DONE
`ifdef RESULT_CHECKSUM_EN
        , CSUM
`endif
    } state_t;

    state_t                        state_reg, state_next;
    logic                          finish_d_reg;
    logic [KEY_W-1:0]              key_sh_reg, key_sh_next;
    logic [KEY_CNT_W-1:0]          key_cnt_reg, key_cnt_next;
    logic [MESSAGE_LOG_LENGTH-1:0] msg_idx_reg, msg_idx_next;
    logic [RAM_WIDTH-1:0]          hold_reg, hold_next;
`ifdef RESULT_CHECKSUM_EN
    logic [RAM_WIDTH-1:0]          csum_reg, csum_next;
`endif

    logic [RAM_WIDTH-1:0] core_bytes [NUM_CORES];
    logic [RAM_WIDTH-1:0] sel_byte;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_core_slice
            assign core_bytes[gi] = a_rdata[gi*RAM_WIDTH +: RAM_WIDTH];
        end
    endgenerate

    // An out-of-range core index reads as zero rather than aliasing another core.
    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (core_ptr == LOG_NUM_CORES'(i)) sel_byte = core_bytes[i];
        end
    end

    // The message index doubles as the A RAM address, so it must be stable through RD_REQ.
    assign a_raddr = msg_idx_reg;
    assign busy    = (state_reg != IDLE) && (state_reg != DONE);

    always_comb begin
        state_next   = state_reg;
        key_sh_next  = key_sh_reg;
        key_cnt_next = key_cnt_reg;
        msg_idx_next = msg_idx_reg;
        hold_next    = hold_reg;
`ifdef RESULT_CHECKSUM_EN
        csum_next    = csum_reg;
`endif
        out_valid    = 1'b0;
        out_data     = '0;
        out_last     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (finish && !finish_d_reg) begin
                    key_sh_next  = key;
                    key_cnt_next = '0;
                    msg_idx_next = '0;
`ifdef RESULT_CHECKSUM_EN
                    csum_next    = '0;
`endif
                    state_next   = success ? KEY : FAILB;
                end
            end
            KEY: begin
                out_valid = 1'b1;
                out_data  = key_sh_reg[KEY_W-1 -: RAM_WIDTH];
                if (out_ready) begin
`ifdef RESULT_CHECKSUM_EN
                    csum_next = csum_reg ^ out_data;
`endif
                    key_sh_next = key_sh_reg << RAM_WIDTH;
                    if (key_cnt_reg == KEY_LAST) begin
                        msg_idx_next = '0;
                        state_next   = RD_REQ;
                    end else begin
                        key_cnt_next = key_cnt_reg + KEY_CNT_W'(1);
                    end
                end
            end
            RD_REQ:  state_next = RD_WAIT;
            RD_WAIT: begin
                hold_next  = sel_byte;
                state_next = MSG;
            end
            MSG: begin
                out_valid = 1'b1;
                out_data  = hold_reg;
`ifdef RESULT_CHECKSUM_EN
                out_last  = 1'b0;
`else
                out_last  = (msg_idx_reg == MSG_LAST);
`endif
                if (out_ready) begin
`ifdef RESULT_CHECKSUM_EN
                    csum_next = csum_reg ^ hold_reg;
`endif
                    if (msg_idx_reg == MSG_LAST) begin
`ifdef RESULT_CHECKSUM_EN
                        state_next = CSUM;
`else
                        state_next = DONE;
`endif
                    end else begin
                        msg_idx_next = msg_idx_reg + MESSAGE_LOG_LENGTH'(1);
                        state_next   = RD_REQ;
                    end
                end
            end
            FAILB: begin
                out_valid = 1'b1;
                out_data  = FAIL_CODE;
                out_last  = 1'b1;
                if (out_ready) state_next = DONE;
            end
`ifdef RESULT_CHECKSUM_EN
            CSUM: begin
                out_valid = 1'b1;
                out_data  = csum_reg;
                out_last  = 1'b1;
                if (out_ready) state_next = DONE;
            end
`endif
            DONE: begin
                if (!finish) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // finish dropping means a new search run has begun; discard this stream.
        if ((state_reg != IDLE) && !finish) begin
            state_next   = IDLE;
            msg_idx_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        // Tracked through reset so a finish held high across reset is not seen as a new edge.
        finish_d_reg <= finish;
        if (reset) begin
            state_reg   <= IDLE;
            key_sh_reg  <= '0;
            key_cnt_reg <= '0;
            msg_idx_reg <= '0;
            hold_reg    <= '0;
`ifdef RESULT_CHECKSUM_EN
            csum_reg    <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            key_sh_reg  <= key_sh_next;
            key_cnt_reg <= key_cnt_next;
            msg_idx_reg <= msg_idx_next;
            hold_reg    <= hold_next;
`ifdef RESULT_CHECKSUM_EN
            csum_reg    <= csum_next;
`endif
        end
    end

endmodule

// File: tb/tb_result_streamer.sv
// Testbench for result_streamer: table of result vectors plus abort and mid-stream reset sequences, checked through a byte scoreboard.
module tb_result_streamer;

`ifdef RESULT_CHECKSUM_EN
    localparam int CSUM_EN = 1;
`else
    localparam int CSUM_EN = 0;
`endif
    localparam int MSG_LEN = 32;
    localparam int SUCCESS_LEN = 3 + MSG_LEN + CSUM_EN;
    localparam int BUDGET = 3000;

    logic        clk, reset, finish, success;
    logic [7:0]  core_ptr;
    logic [23:0] key;
    logic [4:0]  a_raddr;
    logic [15:0] a_rdata;
    logic [7:0]  out_data;
    logic        out_valid, out_ready, out_last, busy;

    result_streamer dut (
        .clk(clk), .reset(reset), .finish(finish), .success(success),
        .core_ptr(core_ptr), .key(key), .a_raddr(a_raddr), .a_rdata(a_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two A RAMs with one-cycle registered read.
    logic [7:0] ram0 [MSG_LEN];
    logic [7:0] ram1 [MSG_LEN];
    logic [7:0] q0, q1;
    always_ff @(posedge clk) begin
        q0 <= ram0[a_raddr];
        q1 <= ram1[a_raddr];
    end
    assign a_rdata = {q1, q0};

    function automatic logic [7:0] ram_val(input int c, input int n);
        if (c == 1) return 8'(8'h61 + n);
        return 8'(8'hC0 ^ (n * 5));
    endfunction

    typedef struct {
        logic [23:0] key;
        logic [7:0]  core;
        logic        success;
        int          rmode;   // 0 ready always, 1 random, 2 never
        int          nbytes;
    } vec_t;

    vec_t       vecs [5];
    logic [8:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;
    int         xfer_cnt = 0;
    int         ready_mode = 0;
    bit         raddr_seen = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_expected(input vec_t v);
        logic [23:0] kv;
        logic [7:0]  b, cs;
        if (!v.success) begin
            exp_q.push_back({1'b1, 8'hEE});
        end else begin
            kv = v.key;
            cs = 8'h00;
            for (int k = 0; k < 3; k++) begin
                b = kv[23:16];
                kv = kv << 8;
                cs ^= b;
                exp_q.push_back({1'b0, b});
            end
            for (int n = 0; n < MSG_LEN; n++) begin
                b = (v.core < 8'd2) ? ram_val(int'(v.core), n) : 8'h00;
                cs ^= b;
                exp_q.push_back({((n == MSG_LEN - 1) && (CSUM_EN == 0)), b});
            end
            if (CSUM_EN != 0) exp_q.push_back({1'b1, cs});
        end
    endtask

    // Ready driver: changes just after the active edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each transfer and checks stall stability.
    initial begin
        logic [8:0] e;
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    xfer_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_byte: got %h last %b, expected no transfer", out_data, out_last);
                    end else begin
                        e = exp_q.pop_front();
                        $display("xfer %0d: data %h last %b (expected %h last %b)", xfer_cnt, out_data, out_last, e[7:0], e[8]);
                        if ({out_last, out_data} !== e) begin
                            errors++;
                            $display("FAIL stream_byte %0d: got %h/%b expected %h/%b", xfer_cnt, out_data, out_last, e[7:0], e[8]);
                        end
                    end
                end
                if (prev_stall) begin
                    checks++;
                    if (!out_valid || out_data !== prev_data || out_last !== prev_last) begin
                        errors++;
                        $display("FAIL stall_hold: got v%b %h/%b expected v1 %h/%b", out_valid, out_data, out_last, prev_data, prev_last);
                    end
                end
                prev_stall = out_valid && !out_ready && finish;
                prev_data  = out_data;
                prev_last  = out_last;
                if (a_raddr != 5'd0) raddr_seen = 1'b1;
            end
        end
    end

    task automatic start_stream(input vec_t v);
        ready_mode = v.rmode;
        key        = v.key;
        core_ptr   = v.core;
        success    = v.success;
        push_expected(v);
        @(posedge clk);
        #1 finish = 1'b1;
        @(posedge clk);
        // success must be ignored after the finish edge
        #1 success = ~v.success;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout: got %0d bytes left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_xfers(input int target);
        int n = 0;
        while (xfer_cnt < target && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: got %0d transfers, expected %0d", xfer_cnt, target);
        end
    endtask

    task automatic wait_stalled();
        int n = 0;
        @(negedge clk);
        while (!(out_valid && !out_ready) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) begin
            checks++;
            errors++;
            $display("FAIL stall_timeout: got valid %b ready %b, expected 1/0", out_valid, out_ready);
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        raddr_seen = 1'b0;
        xfer_cnt   = 0;
        start_stream(v);
        wait_done();
        chk($sformatf("v%0d_busy_done", idx), 32'(busy), 32'd0);
        chk($sformatf("v%0d_valid_done", idx), 32'(out_valid), 32'd0);
        chk($sformatf("v%0d_nbytes", idx), 32'(xfer_cnt), 32'(v.nbytes));
        if (!v.success) chk($sformatf("v%0d_raddr_idle", idx), 32'(raddr_seen), 32'd0);
        // DONE must not re-stream while finish stays high
        repeat (5) @(posedge clk);
        #1 chk($sformatf("v%0d_no_restream", idx), 32'(busy), 32'd0);
        finish     = 1'b0;
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1 chk($sformatf("v%0d_idle_after", idx), 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < 2; c++)
            for (int n = 0; n < MSG_LEN; n++) begin
                if (c == 0) ram0[n] = ram_val(0, n);
                else        ram1[n] = ram_val(1, n);
            end

        vecs[0] = '{key: 24'h0003FF, core: 8'd1, success: 1'b0, rmode: 0, nbytes: 1};
        vecs[1] = '{key: 24'h0003FF, core: 8'd1, success: 1'b1, rmode: 0, nbytes: SUCCESS_LEN};
        vecs[2] = '{key: 24'h0003FF, core: 8'd1, success: 1'b1, rmode: 1, nbytes: SUCCESS_LEN};
        vecs[3] = '{key: 24'hA5C33C, core: 8'd0, success: 1'b1, rmode: 1, nbytes: SUCCESS_LEN};
        vecs[4] = '{key: 24'h123456, core: 8'd5, success: 1'b1, rmode: 0, nbytes: SUCCESS_LEN};

        reset    = 1'b1;
        finish   = 1'b0;
        success  = 1'b0;
        key      = 24'h0;
        core_ptr = 8'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last",  32'(out_last),  32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_raddr", 32'(a_raddr),   32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) run_vec(i);

        // Abort: finish falls while the 11th byte is stalled.
        xfer_cnt = 0;
        start_stream(vecs[1]);
        wait_xfers(10);
        ready_mode = 2;
        wait_stalled();
        @(posedge clk);
        #1 finish = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy",  32'(busy),      32'd0);
        chk("abort_xfers", 32'(xfer_cnt),  32'd10);
        exp_q.delete();
        ready_mode = 0;
        run_vec(1);

        // Reset while stalled in MSG with finish held high.
        xfer_cnt = 0;
        start_stream(vecs[1]);
        wait_xfers(5);
        ready_mode = 2;
        wait_stalled();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_busy",  32'(busy),      32'd0);
        chk("mrst_raddr", 32'(a_raddr),   32'd0);
        chk("mrst_last",  32'(out_last),  32'd0);
        exp_q.delete();
        reset      = 1'b0;
        ready_mode = 0;
        xfer_cnt   = 0;
        repeat (20) @(posedge clk);
        #1;
        chk("mrst_no_restart_busy",  32'(busy),     32'd0);
        chk("mrst_no_restart_xfers", 32'(xfer_cnt), 32'd0);
        finish = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run_vec(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
